change_dispenser: RTL and testbench
===================================

# change_dispenser

Controller that pays out the change amount produced by the vending FSM (`exchange_coin`). It does this through a single shared coin-eject mechanism fed by three coin tubes (10, 5, 1). It accepts one payout request at a time and sequences greedy coin selection against per-tube inventory counters. It hand-shakes each coin with the mechanism, reports any unpayable remainder, and latches a fault when the mechanism jams.

## Interface
Parameters:
- `AMT_W`, 32: width of amount and remainder, matches `exchange_coin`.
- `CNT_W`, 8: width of each tube inventory counter.
- `INIT_10`, 20: count of 10-coins after reset.
- `INIT_5`, 20: count of 5-coins after reset.
- `INIT_1`, 50: count of 1-coins after reset.
- `TMO_CYC`, 15: maximum cycles to wait for `eject_ack` per coin.

Ports:
- `clock` in 1: single clock, all state changes on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `req` in 1: payout request, sampled only when `busy`=0.
- `amount` in AMT_W: change to pay, captured with `req`.
- `refill_10`, `refill_5`, `refill_1` in 1 each: add one coin to that tube per cycle high.
- `eject_ack` in 1: mechanism has dropped the currently requested coin.
- `eject_10`, `eject_5`, `eject_1` out 1 each: request one coin of that type; at most one is high.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of each accepted request.
- `short_amt` out AMT_W: unpaid remainder, valid from `done` until the next accepted `req`.
- `fault` out 1: sticky, set when `eject_ack` times out.
- `cnt_10`, `cnt_5`, `cnt_1` out CNT_W each: current tube inventories.

## Operation
- States are IDLE, SELECT, EJECT and DONE. Outputs are Moore-decoded from the state and the registered selection.
- IDLE:
  - `req`=1 loads `remain`←`amount` and the next state is SELECT.
  - `req`=0 holds IDLE.
- SELECT makes a priority choice. The first matching rule wins:
  - `fault`=1 → DONE.
  - `remain`=0 → DONE.
  - `remain`≥10 and `cnt_10`>0 → select 10, go to EJECT.
  - `remain`≥5 and `cnt_5`>0 → select 5, go to EJECT.
  - `remain`≥1 and `cnt_1`>0 → select 1, go to EJECT.
  - Otherwise → DONE.
- EJECT:
  - The selected `eject_*` is held high for the whole state and the timer counts up from 0.
  - `eject_ack`=1: the selected count decrements by 1, `remain` decrements by the denomination, the timer clears, and the next state is SELECT.
  - The timer reaching `TMO_CYC` without an ack: `fault`←1, no decrement, next state DONE.
- DONE:
  - `short_amt`←`remain`, `done`=1 for this cycle only, next state IDLE.
- `eject_ack` outside EJECT is ignored.
- `req` while `busy`=1 is ignored and is not queued.
- Refill:
  - A refill applies in any state.
  - A refill and an ack-decrement on the same tube in the same cycle cancel, leaving the count unchanged.
  - Counts saturate at 2^CNT_W−1 and never go below 0.
- Width rules:
  - `remain` is AMT_W unsigned and never underflows, because selection guarantees `remain` ≥ the denomination.
  - Comparisons are unsigned.
- `fault` clears only on `clear`. While `fault`=1, every request completes through SELECT→DONE with `short_amt`=`amount`.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`, `done`, `fault` and all `eject_*` = 0.
  - `short_amt` = 0.
  - `cnt_10`/`cnt_5`/`cnt_1` = `INIT_10`/`INIT_5`/`INIT_1`.
  - `remain` and the timer = 0.
- Sequence for `req` sampled at edge k:
  - `busy`=1 from k.
  - SELECT in cycle k..k+1.
  - The first `eject_*` goes high at edge k+1.
- Per coin, with the ack sampled at edge a:
  - `eject_*` drops at a.
  - The next `eject_*` rises at a+1.
  - Minimum of 2 cycles per coin.
- The end of a request (SELECT→DONE at edge d) produces:
  - `done` and the updated `short_amt` visible in cycle d..d+1.
  - IDLE at d+1.
  - A new `req` can be accepted at edge d+1 at the earliest.
- `amount`=0 yields `done` 2 cycles after `req` with `short_amt`=0.
- `clear` mid-operation:
  - The request is aborted: no `done` pulse and `eject_*` low at the next edge.
  - Counts reload to their INIT values.

## Structure
- Package `vend_pkg` holds:
  - denomination constants 10/5/1;
  - the state enum (IDLE, SELECT, EJECT, DONE);
  - the 2-bit coin-select encoding (NONE, C10, C5, C1).
- Sub-module `coin_tube_counter`, instantiated three times: saturating up/down counter with parameter INIT, inputs `inc`/`dec`, output `count`.
- The top level holds the FSM, `remain`, the timeout timer and the `short_amt` register.

## Test plan
- Default inventory, `amount`=27 → ejects 10,10,5,1,1 in that order; `short_amt`=0; `cnt_10`=18, `cnt_5`=19, `cnt_1`=48.
- `cnt_10`=0 (INIT_10=0), `amount`=15 → ejects 5,5,5; `done` with `short_amt`=0.
- INIT_5=0, INIT_1=2, `amount`=8 → ejects 1,1; `short_amt`=6; `cnt_1`=0.
- Mechanism never acks, `amount`=10 → `eject_10` high for 15 cycles, then `fault`=1, `short_amt`=10, `cnt_10` unchanged. A following `req` with `amount`=3 → no eject, `short_amt`=3.
- `refill_1` asserted in the same cycle as an ack for a 1-coin → `cnt_1` unchanged. A `req` pulsed while `busy` → ignored, only one `done` pulse.
- `clear` asserted while in EJECT mid-payout → next cycle shows IDLE, `busy`=0, no `done`, counts equal to the INIT values.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending change path.
// Denominations, FSM states and coin-select codes.
package vend_pkg;

  localparam int unsigned DEN_10 = 10;
  localparam int unsigned DEN_5  = 5;
  localparam int unsigned DEN_1  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_C10,
    SEL_C5,
    SEL_C1
  } coin_sel_t;

  function automatic int unsigned coin_value(coin_sel_t s);
    int unsigned v;
    v = 0;
    case (s)
      SEL_C10: v = DEN_10;
      SEL_C5:  v = DEN_5;
      SEL_C1:  v = DEN_1;
      default: v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_tube_counter.sv
// Saturating inventory counter for one coin tube.
// Simultaneous inc and dec cancel out.
module coin_tube_counter #(
  parameter int CNT_W = 8,
  parameter int INIT  = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_V  = '1;
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= INIT_V;
    end else if (inc && !dec) begin
      if (count != MAX_V)
        count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout through one shared coin-eject mechanism.
// Three tubes (10/5/1), per-coin ack handshake, sticky jam fault.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W   = 32,
  parameter int CNT_W   = 8,
  parameter int INIT_10 = 20,
  parameter int INIT_5  = 20,
  parameter int INIT_1  = 50,
  parameter int TMO_CYC = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill_10,
  input  logic             refill_5,
  input  logic             refill_1,
  input  logic             eject_ack,
  output logic             eject_10,
  output logic             eject_5,
  output logic             eject_1,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] short_amt,
  output logic             fault,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_1
);

  localparam int TMR_W = $clog2(TMO_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);

  state_t           state;
  coin_sel_t        sel;
  coin_sel_t        pick;
  logic [AMT_W-1:0] remain;
  logic [AMT_W-1:0] sel_val;
  logic [TMR_W-1:0] timer;
  logic             in_eject;
  logic             ack_hit;
  logic             tmo_hit;
  logic             dec_10;
  logic             dec_5;
  logic             dec_1;

  assign in_eject = (state == ST_EJECT);
  assign ack_hit  = in_eject && eject_ack;
  assign tmo_hit  = in_eject && !eject_ack && (timer == TMR_LAST);
  assign sel_val  = AMT_W'(coin_value(sel));

  // Largest affordable coin that is still in stock wins.
  always_comb begin
    pick = SEL_NONE;
    if (fault || remain == '0)
      pick = SEL_NONE;
    else if (remain >= AMT_W'(DEN_10) && cnt_10 != '0)
      pick = SEL_C10;
    else if (remain >= AMT_W'(DEN_5) && cnt_5 != '0)
      pick = SEL_C5;
    else if (remain >= AMT_W'(DEN_1) && cnt_1 != '0)
      pick = SEL_C1;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= ST_IDLE;
      sel       <= SEL_NONE;
      remain    <= '0;
      timer     <= '0;
      short_amt <= '0;
      fault     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            remain <= amount;
            state  <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (pick == SEL_NONE) begin
            short_amt <= remain;
            sel       <= SEL_NONE;
            state     <= ST_DONE;
          end else begin
            sel   <= pick;
            timer <= '0;
            state <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (eject_ack) begin
            remain <= remain - sel_val;
            timer  <= '0;
            sel    <= SEL_NONE;
            state  <= ST_SELECT;
          end else if (tmo_hit) begin
            fault     <= 1'b1;
            short_amt <= remain;
            timer     <= '0;
            sel       <= SEL_NONE;
            state     <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign eject_10 = in_eject && (sel == SEL_C10);
  assign eject_5  = in_eject && (sel == SEL_C5);
  assign eject_1  = in_eject && (sel == SEL_C1);

  assign dec_10 = ack_hit && (sel == SEL_C10);
  assign dec_5  = ack_hit && (sel == SEL_C5);
  assign dec_1  = ack_hit && (sel == SEL_C1);

  coin_tube_counter #(
    .CNT_W(CNT_W),
    .INIT (INIT_10)
  ) u_tube_10 (
    .clock(clock),
    .clear(clear),
    .inc  (refill_10),
    .dec  (dec_10),
    .count(cnt_10)
  );

  coin_tube_counter #(
    .CNT_W(CNT_W),
    .INIT (INIT_5)
  ) u_tube_5 (
    .clock(clock),
    .clear(clear),
    .inc  (refill_5),
    .dec  (dec_5),
    .count(cnt_5)
  );

  coin_tube_counter #(
    .CNT_W(CNT_W),
    .INIT (INIT_1)
  ) u_tube_1 (
    .clock(clock),
    .clear(clear),
    .inc  (refill_1),
    .dec  (dec_1),
    .count(cnt_1)
  );

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table, greedy reference
// model with random amounts, and hand-written corner sequences.
module tb_change_dispenser;

  localparam int AW = 32;
  localparam int CW = 8;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  logic          req  [2];
  logic          ack  [2];
  logic          r10  [2];
  logic          r5   [2];
  logic          r1   [2];
  logic [AW-1:0] amt  [2];
  logic          ej10 [2];
  logic          ej5  [2];
  logic          ej1  [2];
  logic          busy [2];
  logic          done [2];
  logic          fault[2];
  logic [AW-1:0] shrt [2];
  logic [CW-1:0] c10  [2];
  logic [CW-1:0] c5   [2];
  logic [CW-1:0] c1   [2];

  change_dispenser u_a (
    .clock(clock), .clear(clear), .req(req[0]), .amount(amt[0]),
    .refill_10(r10[0]), .refill_5(r5[0]), .refill_1(r1[0]),
    .eject_ack(ack[0]), .eject_10(ej10[0]), .eject_5(ej5[0]),
    .eject_1(ej1[0]), .busy(busy[0]), .done(done[0]),
    .short_amt(shrt[0]), .fault(fault[0]),
    .cnt_10(c10[0]), .cnt_5(c5[0]), .cnt_1(c1[0])
  );

  change_dispenser #(
    .INIT_10(0), .INIT_5(3), .INIT_1(2)
  ) u_b (
    .clock(clock), .clear(clear), .req(req[1]), .amount(amt[1]),
    .refill_10(r10[1]), .refill_5(r5[1]), .refill_1(r1[1]),
    .eject_ack(ack[1]), .eject_10(ej10[1]), .eject_5(ej5[1]),
    .eject_1(ej1[1]), .busy(busy[1]), .done(done[1]),
    .short_amt(shrt[1]), .fault(fault[1]),
    .cnt_10(c10[1]), .cnt_5(c5[1]), .cnt_1(c1[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt[2] = '{0, 0};
  int onehot_bad = 0;
  int obs_q[$];
  int exp_q[$];
  int mc[3];
  int den[3] = '{10, 5, 1};

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d])
        done_cnt[d] <= done_cnt[d] + 1;
      if (int'(ej10[d]) + int'(ej5[d]) + int'(ej1[d]) > 1)
        onehot_bad <= onehot_bad + 1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Greedy payout computed arithmetically from the coin rules.
  task automatic model_pay(input int a, output int s);
    int rem;
    int n;
    exp_q.delete();
    rem = a;
    for (int i = 0; i < 3; i++) begin
      n = rem / den[i];
      if (n > mc[i]) n = mc[i];
      rem -= n * den[i];
      mc[i] -= n;
      repeat (n) exp_q.push_back(den[i]);
    end
    s = rem;
  endtask

  task automatic model_refill(input int i);
    mc[i] = (mc[i] + 1 > 255) ? 255 : mc[i] + 1;
  endtask

  task automatic pay(input int d, input int a, input int dly,
                     input bit ack_en, output int s, output int ejc);
    bit ok;
    ok = 0;
    s = -1;
    ejc = 0;
    obs_q.delete();
    @(negedge clock);
    req[d] = 1'b1;
    amt[d] = AW'(a);
    @(negedge clock);
    req[d] = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      if (done[d]) begin
        s = int'(shrt[d]);
        ok = 1;
      end else if (ej10[d] || ej5[d] || ej1[d]) begin
        ejc++;
        if (ack_en) begin
          obs_q.push_back(ej10[d] ? 10 : (ej5[d] ? 5 : 1));
          repeat (dly) @(negedge clock);
          ack[d] = 1'b1;
          @(negedge clock);
          ack[d] = 1'b0;
        end else begin
          @(negedge clock);
        end
      end else begin
        @(negedge clock);
      end
    end
    chk("pay_done_seen", ok, 1);
  endtask

  typedef struct {
    int d;
    int a;
    int dly;
    int s;
    int e10;
    int e5;
    int e1;
  } vec_t;

  vec_t tbl[9];
  int ini[2][3] = '{'{20, 20, 50}, '{0, 3, 2}};
  int ord[5] = '{10, 10, 5, 1, 1};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, ejc, es, a, dly, dc, sum;
    bit eq;

    tbl[0] = '{0, 27,  0, 0, 18, 19, 48};
    tbl[1] = '{0, 0,   1, 0, 18, 19, 48};
    tbl[2] = '{0, 3,   2, 0, 18, 19, 45};
    tbl[3] = '{0, 14,  0, 0, 17, 19, 41};
    tbl[4] = '{0, 9,   3, 0, 17, 18, 37};
    tbl[5] = '{0, 200, 1, 0, 0,  12, 37};
    tbl[6] = '{0, 13,  0, 0, 0,  10, 34};
    tbl[7] = '{1, 15,  0, 0, 0,  0,  2};
    tbl[8] = '{1, 8,   2, 6, 0,  0,  0};

    for (int d = 0; d < 2; d++) begin
      req[d] = 0; ack[d] = 0; amt[d] = '0;
      r10[d] = 0; r5[d] = 0; r1[d] = 0;
    end
    clear = 1'b1;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_fault", fault[d], 0);
      chk("rst_eject", ej10[d] | ej5[d] | ej1[d], 0);
      chk("rst_short", shrt[d], 0);
      chk("rst_c10", c10[d], ini[d][0]);
      chk("rst_c5", c5[d], ini[d][1]);
      chk("rst_c1", c1[d], ini[d][2]);
    end
    clear = 1'b0;

    for (int i = 0; i < 9; i++) begin
      pay(tbl[i].d, tbl[i].a, tbl[i].dly, 1'b1, s, ejc);
      chk("tbl_short", s, tbl[i].s);
      chk("tbl_c10", c10[tbl[i].d], tbl[i].e10);
      chk("tbl_c5", c5[tbl[i].d], tbl[i].e5);
      chk("tbl_c1", c1[tbl[i].d], tbl[i].e1);
      sum = 0;
      foreach (obs_q[k]) sum += obs_q[k];
      chk("tbl_paid", sum, tbl[i].a - tbl[i].s);
      if (i == 0) begin
        chk("tbl27_ncoins", obs_q.size(), 5);
        for (int k = 0; k < 5 && k < obs_q.size(); k++)
          chk("tbl27_order", obs_q[k], ord[k]);
      end
    end

    mc = '{0, 10, 34};
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        r10[0] = 1'($urandom_range(0, 1));
        r5[0]  = 1'($urandom_range(0, 1));
        r1[0]  = 1'($urandom_range(0, 1));
        if (r10[0]) model_refill(0);
        if (r5[0]) model_refill(1);
        if (r1[0]) model_refill(2);
      end
      @(negedge clock);
      r10[0] = 0; r5[0] = 0; r1[0] = 0;
      a = int'($urandom_range(0, 70));
      dly = int'($urandom_range(0, 3));
      model_pay(a, es);
      pay(0, a, dly, 1'b1, s, ejc);
      eq = (obs_q.size() == exp_q.size());
      for (int k = 0; k < obs_q.size() && eq; k++)
        if (obs_q[k] != exp_q[k]) eq = 0;
      chk("rnd_seq", eq, 1);
      chk("rnd_short", s, es);
      chk("rnd_c10", c10[0], mc[0]);
      chk("rnd_c5", c5[0], mc[1]);
      chk("rnd_c1", c1[0], mc[2]);
    end

    @(negedge clock);
    r10[0] = 1; r5[0] = 1; r1[0] = 1;
    repeat (3) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) model_refill(i);
    end
    r10[0] = 0; r5[0] = 0; r1[0] = 0;
    chk("refill_c1", c1[0], mc[2]);

    dc = done_cnt[0];
    @(negedge clock);
    req[0] = 1; amt[0] = 1;
    @(negedge clock);
    req[0] = 0;
    @(negedge clock);
    chk("rc_ej1", ej1[0], 1);
    req[0] = 1; ack[0] = 1; r1[0] = 1;
    @(negedge clock);
    req[0] = 0; ack[0] = 0; r1[0] = 0;
    chk("rc_c1_cancel", c1[0], mc[2]);
    chk("rc_ej1_drop", ej1[0], 0);
    for (int c = 0; c < 20 && busy[0]; c++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk("rc_idle", busy[0], 0);
    chk("rc_one_done", done_cnt[0] - dc, 1);
    chk("rc_short", shrt[0], 0);

    pay(0, 10, 0, 1'b0, s, ejc);
    chk("tmo_eject_cycles", ejc, 15);
    chk("tmo_fault", fault[0], 1);
    chk("tmo_short", s, 10);
    chk("tmo_c10", c10[0], mc[0]);
    pay(0, 3, 0, 1'b1, s, ejc);
    chk("flt_no_eject", ejc, 0);
    chk("flt_short", s, 3);
    chk("flt_sticky", fault[0], 1);

    clear = 1;
    @(negedge clock);
    clear = 0;
    chk("clr_fault", fault[0], 0);
    dc = done_cnt[0];
    @(negedge clock);
    req[0] = 1; amt[0] = 27;
    @(negedge clock);
    req[0] = 0;
    @(negedge clock);
    chk("mid_ej10", ej10[0], 1);
    repeat (2) @(negedge clock);
    clear = 1;
    @(negedge clock);
    clear = 0;
    chk("mid_busy", busy[0], 0);
    chk("mid_eject", ej10[0] | ej5[0] | ej1[0], 0);
    chk("mid_c10", c10[0], 20);
    chk("mid_c5", c5[0], 20);
    chk("mid_c1", c1[0], 50);
    repeat (4) @(negedge clock);
    chk("mid_no_done", done_cnt[0] - dc, 0);
    chk("onehot_violations", onehot_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
